// File: rtl/ecp8_pkg.sv
// rtl/ecp8_pkg.sv - shared state encoding and opcode constants for the ECP8 fetch sequencer
package ecp8_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_IMM    = 2'b00;
  localparam logic [1:0] OP_ALU    = 2'b01;
  localparam logic [1:0] OP_COPY   = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

endpackage

// File: rtl/fetch_seq_dec.sv
// rtl/fetch_seq_dec.sv - ECP8 opcode decoder: one-hot enable from IR[7:6]
module fetch_seq_dec
  import ecp8_pkg::*;
#(
  parameter int UUID = 0
) (
  input  logic [1:0] op,
  output logic       imm,
  output logic       alu,
  output logic       copy,
  output logic       branch
);

  localparam int unused_uuid = UUID;

  always_comb begin
    imm    = 1'b0;
    alu    = 1'b0;
    copy   = 1'b0;
    branch = 1'b0;
    case (op)
      OP_IMM:  imm    = 1'b1;
      OP_ALU:  alu    = 1'b1;
      OP_COPY: copy   = 1'b1;
      default: branch = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - fetch/execute/halt sequencer: fetches one byte, issues one execute strobe
module fetch_seq
  import ecp8_pkg::*;
#(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [7:0] Instruction,
  output logic       IMM_EN,
  output logic       ALU_EN,
  output logic       COPY_EN,
  output logic       BRANCH_EN,
  input  logic       stall,
  input  logic       cond_true,
  input  logic [7:0] branch_target,
  input  logic       halt_req,
  output logic [7:0] pc,
  output logic       halted
);

  localparam unused_name = NAME;

  state_t     state, state_next;
  logic [7:0] ir, ir_next, pc_next;
  logic       exec_go;
  logic       dec_imm, dec_alu, dec_copy, dec_branch;

  fetch_seq_dec #(.UUID(UUID ^ 1)) u_dec (
    .op     (ir[7:6]),
    .imm    (dec_imm),
    .alu    (dec_alu),
    .copy   (dec_copy),
    .branch (dec_branch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    exec_go    = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ack) begin
          ir_next    = mem_data;
          pc_next    = pc + 8'd1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          exec_go = 1'b1;
          // a taken branch replaces the increment already applied at fetch
          if (ir[7:6] == OP_BRANCH && cond_true) pc_next = branch_target;
          state_next = halt_req ? HALT : FETCH;
        end
      end
      HALT: begin
        if (!halt_req) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // state already sits in FETCH during reset, so the request is masked by rst itself
  assign mem_req     = (state == FETCH) && !rst;
  assign mem_addr    = pc;
  assign Instruction = ir;
  assign halted      = (state == HALT);
  assign IMM_EN      = exec_go && dec_imm;
  assign ALU_EN      = exec_go && dec_alu;
  assign COPY_EN     = exec_go && dec_copy;
  assign BRANCH_EN   = exec_go && dec_branch;

endmodule
